cpu_step_ctrl: RTL

- Sits directly downstream of the board clock divider on the multi-cycle MIPS board build.
- Consumes the divider's slow square wave and a raw step push-button.
- Produces a single-cycle CPU clock-enable pulse on clk_in: one pulse per slow_clk rising edge in run mode, or one pulse per debounced button press in step mode.
- Also keeps a count of issued enable pulses for the 7-seg/LED debug display.

---
 rtl/cpu_step_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/cpu_step_ctrl.sv
// cpu_step_ctrl: turns the divider's slow square wave (run mode) or a
// debounced step push-button (step mode) into single-cycle CPU clock-enable
// pulses, and counts the pulses for the debug display.
module cpu_step_ctrl #(
  parameter int DEB_CYCLES = 1000000,
  parameter int CNT_W      = 16
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             slow_clk,
  input  logic             btn_step,
  input  logic             mode_run,
  output logic             cpu_en,
  output logic [CNT_W-1:0] step_count,
  output logic             running
);

  localparam int             DW      = $clog2(DEB_CYCLES);
  localparam logic [DW-1:0]  DEB_MAX = DW'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } deb_state_t;

  // Bit order in the synchronizer vectors: {mode, btn, slow}
  logic [2:0]    sync1, sync2;
  logic          slow_s, btn_s, mode_s;
  logic          slow_prev, slow_tick;
  deb_state_t    state, state_nxt;
  logic [DW-1:0] deb_cnt, deb_cnt_nxt;
  logic          press_tick;
  logic          en_nxt;

  assign slow_s = sync2[0];
  assign btn_s  = sync2[1];
  assign mode_s = sync2[2];

  // Two-flop synchronizers for the three asynchronous inputs
  always_ff @(posedge clk_in) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {mode_run, btn_step, slow_clk};
      sync2 <= sync1;
    end
  end

  // Rising-edge history of the synchronized slow clock
  always_ff @(posedge clk_in) begin
    if (reset) slow_prev <= 1'b0;
    else       slow_prev <= slow_s;
  end

  assign slow_tick = slow_s & ~slow_prev;

  // Debounce state register
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state   <= IDLE;
      deb_cnt <= '0;
    end else begin
      state   <= state_nxt;
      deb_cnt <= deb_cnt_nxt;
    end
  end

  // Debounce next-state: a press must stay high DEB_CYCLES cycles in
  // PRESS_WAIT to fire once; a release must stay low as long to re-arm
  always_comb begin
    state_nxt   = state;
    deb_cnt_nxt = deb_cnt;
    press_tick  = 1'b0;
    case (state)
      IDLE: begin
        if (btn_s) begin
          state_nxt   = PRESS_WAIT;
          deb_cnt_nxt = '0;
        end
      end
      PRESS_WAIT: begin
        if (!btn_s) begin
          state_nxt = IDLE;
        end else if (deb_cnt == DEB_MAX) begin
          state_nxt  = HELD;
          press_tick = 1'b1;
        end else begin
          deb_cnt_nxt = deb_cnt + 1'b1;
        end
      end
      HELD: begin
        if (!btn_s) begin
          state_nxt   = RELEASE_WAIT;
          deb_cnt_nxt = '0;
        end
      end
      RELEASE_WAIT: begin
        if (btn_s) begin
          state_nxt = HELD;
        end else if (deb_cnt == DEB_MAX) begin
          state_nxt = IDLE;
        end else begin
          deb_cnt_nxt = deb_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt   = IDLE;
        deb_cnt_nxt = '0;
      end
    endcase
  end

  // Source select uses the current synchronized mode, so nothing is queued
  // across a mode switch; the unselected tick is simply dropped
  assign en_nxt = mode_s ? slow_tick : press_tick;

  // Registered enable, wrapping pulse counter and mode LED
  always_ff @(posedge clk_in) begin
    if (reset) begin
      cpu_en     <= 1'b0;
      step_count <= '0;
      running    <= 1'b0;
    end else begin
      cpu_en  <= en_nxt;
      running <= mode_s;
      if (en_nxt) step_count <= step_count + 1'b1;
    end
  end

endmodule
